// File: rtl/multicycle_ctrl.sv
// Control FSM for a multicycle MIPS datapath with memory-ready stalls, timeout and illegal-opcode trapping.
// Optional JUMP_EN macro: when defined, opcode 0x02 decodes to the JUMP state.
module multicycle_ctrl #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic [1:0] pc_source,
    output logic [3:0] state,
    output logic       instr_done,
    output logic [1:0] err_code
);

    localparam int unsigned CW = $clog2(MAX_WAIT + 1);

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
`ifdef JUMP_EN
    localparam logic [5:0] OP_J    = 6'h02;
`endif

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
`ifdef JUMP_EN
        S_JUMP   = 4'd11,
`endif
        S_ERROR  = 4'd15
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [1:0]      r_err;
    logic [1:0]      w_next_err;
    logic [CW-1:0]   r_wait_cnt;
    logic            w_timeout;
    logic            w_mem_state;

    assign state    = r_state;
    assign err_code = r_err;

    assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
    assign w_timeout   = (r_wait_cnt == CW'(MAX_WAIT)) && !mem_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_FETCH;
            r_err      <= ERR_NONE;
            r_wait_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            r_err   <= w_next_err;
            if (w_next_state != r_state)
                r_wait_cnt <= '0;
            else if (w_mem_state && !mem_ready)
                r_wait_cnt <= r_wait_cnt + CW'(1);
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_err   = r_err;
        case (r_state)
            S_FETCH: begin
                if (mem_ready) begin
                    w_next_state = S_DECODE;
                end else if (w_timeout) begin
                    w_next_state = S_ERROR;
                    w_next_err   = ERR_TIMEOUT;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: w_next_state = S_MEMADR;
                    OP_R:         w_next_state = S_EXEC;
                    OP_BEQ:       w_next_state = S_BRANCH;
                    OP_ADDI:      w_next_state = S_ADDIEX;
`ifdef JUMP_EN
                    OP_J:         w_next_state = S_JUMP;
`endif
                    default: begin
                        w_next_state = S_ERROR;
                        w_next_err   = ERR_ILLEGAL;
                    end
                endcase
            end
            S_MEMADR: w_next_state = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD, S_MEMWR: begin
                if (mem_ready) begin
                    w_next_state = (r_state == S_MEMRD) ? S_MEMWB : S_FETCH;
                end else if (w_timeout) begin
                    w_next_state = S_ERROR;
                    w_next_err   = ERR_TIMEOUT;
                end
            end
            S_EXEC:   w_next_state = S_ALUWB;
            S_ADDIEX: w_next_state = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH: w_next_state = S_FETCH;
`ifdef JUMP_EN
            S_JUMP:   w_next_state = S_FETCH;
`endif
            S_ERROR:  w_next_state = S_ERROR;
            default: begin
                w_next_state = S_ERROR;
                w_next_err   = ERR_ILLEGAL;
            end
        endcase
    end

    // Moore decode; FETCH's IR/PC load waits on mem_ready, and reset low masks everything
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 3'b000;
        pc_source     = 2'b00;
        instr_done    = 1'b0;
        if (reset) begin
            case (r_state)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: alu_src_b = 2'b11;
                S_MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_MEMRD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEMWR: begin
                    mem_write  = 1'b1;
                    i_or_d     = 1'b1;
                    instr_done = mem_ready;
                end
                S_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = 3'b010;
                end
                S_ALUWB: begin
                    reg_write  = 1'b1;
                    reg_dst    = 1'b1;
                    instr_done = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = 3'b001;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                    instr_done    = 1'b1;
                end
                S_ADDIEX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_ADDIWB: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
`ifdef JUMP_EN
                S_JUMP: begin
                    pc_write   = 1'b1;
                    pc_source  = 2'b10;
                    instr_done = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction expected state trajectories with random memory stalls.
// Honours the JUMP_EN macro the same way the design does.
module tb_multicycle_ctrl;

    localparam int unsigned MAX_WAIT = 15;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] opcode = 6'h00;
    logic       mem_ready = 1'b0;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, pc_source, err_code;
    logic [2:0] alu_op;
    logic [3:0] state;
    logic       instr_done;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    logic [1:0] exp_err = 2'b00;

    multicycle_ctrl #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .state(state), .instr_done(instr_done),
        .err_code(err_code)
    );

    always #5 clk = ~clk;

    wire [16:0] w_obs_vec = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                             mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};

    // Strobe table from the control-signal listing, packed in the same order as w_obs_vec
    function automatic logic [16:0] exp_vec(input int st, input logic rdy);
        logic pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa;
        logic [1:0] asb, psrc;
        logic [2:0] aop;
        {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa} = '0;
        asb = 2'b00; aop = 3'b000; psrc = 2'b00;
        case (st)
            0:  begin mr = 1; asb = 2'b01; pw = rdy; irw = rdy; end
            1:  asb = 2'b11;
            2:  begin asa = 1; asb = 2'b10; end
            3:  begin mr = 1; iod = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mw = 1; iod = 1; end
            6:  begin asa = 1; aop = 3'b010; end
            7:  begin rw = 1; rd = 1; end
            8:  begin asa = 1; aop = 3'b001; pwc = 1; psrc = 2'b01; end
            9:  begin asa = 1; asb = 2'b10; end
            10: rw = 1;
            11: begin pw = 1; psrc = 2'b10; end
            default: ;
        endcase
        return {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa, asb, aop, psrc};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    // Called just after a rising edge: drive, check mid-cycle, advance one clock
    task automatic step(input int st, input logic rdy, input logic done_exp);
        reset = 1'b1;
        mem_ready = rdy;
        @(negedge clk);
        chk("state", 32'(state), 32'(st));
        chk("strobes", 32'(w_obs_vec), 32'(exp_vec(st, rdy)));
        chk("instr_done", 32'(instr_done), 32'(done_exp));
        chk("err_code", 32'(err_code), 32'(exp_err));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        for (int i = 0; i < n; i++) begin
            mem_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("rst_strobes", 32'(w_obs_vec), 32'd0);
            chk("rst_done", 32'(instr_done), 32'd0);
            @(posedge clk);
            #1;
            chk("rst_state", 32'(state), 32'd0);
            chk("rst_err", 32'(err_code), 32'd0);
        end
        exp_err = 2'b00;
    endtask

    task automatic mem_phase(input int st, input int w, input logic done_on_rdy, output bit to);
        to = (w > int'(MAX_WAIT));
        for (int i = 0; i < (to ? int'(MAX_WAIT) + 1 : w); i++) step(st, 1'b0, 1'b0);
        if (to) exp_err = 2'b10;
        else    step(st, 1'b1, done_on_rdy);
    endtask

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expected trajectory of one instruction; fw/mw are mem_ready-low cycles in fetch / data access
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
        bit err;
        opcode = op;
        mem_phase(0, fw, 1'b0, err);
        if (!err) begin
            step(1, rnd(), 1'b0);
            case (op)
                6'h00: begin step(6, rnd(), 1'b0); step(7, rnd(), 1'b1); end
                6'h23: begin
                    step(2, rnd(), 1'b0);
                    mem_phase(3, mw, 1'b0, err);
                    if (!err) step(4, rnd(), 1'b1);
                end
                6'h2B: begin step(2, rnd(), 1'b0); mem_phase(5, mw, 1'b1, err); end
                6'h04: step(8, rnd(), 1'b1);
                6'h08: begin step(9, rnd(), 1'b0); step(10, rnd(), 1'b1); end
`ifdef JUMP_EN
                6'h02: step(11, rnd(), 1'b1);
`endif
                default: begin err = 1; exp_err = 2'b01; end
            endcase
        end
        if (err) begin
            for (int i = 0; i < 3; i++) step(15, rnd(), 1'b0);
            do_reset(1);
        end
    endtask

    initial begin
        logic [5:0] legal_ops [6];
        legal_ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02};

        do_reset(2);
        run_instr(6'h23, 0, 0);
        run_instr(6'h00, 0, 0);
        run_instr(6'h00, 3, 0);
        run_instr(6'h2B, 0, 16);
        run_instr(6'h3F, 0, 0);
        run_instr(6'h02, 0, 0);
        run_instr(6'h04, 1, 0);
        run_instr(6'h08, 0, 0);
        run_instr(6'h23, int'(MAX_WAIT), int'(MAX_WAIT));
        run_instr(6'h2B, 2, int'(MAX_WAIT));
        run_instr(6'h23, int'(MAX_WAIT) + 1, 0);
        run_instr(6'h23, 0, int'(MAX_WAIT) + 1);

        // abandon an lw in MEMADR, then run a clean instruction
        opcode = 6'h23;
        step(0, 1'b1, 1'b0);
        step(1, rnd(), 1'b0);
        step(2, rnd(), 1'b0);
        do_reset(1);
        run_instr(6'h00, 0, 0);

        for (int k = 0; k < 60; k++) begin
            logic [5:0] op;
            int fw, mw;
            op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 5)];
            fw = ($urandom_range(0, 15) == 0) ? int'(MAX_WAIT) + 1 : int'($urandom_range(0, 4));
            mw = ($urandom_range(0, 15) == 0) ? int'(MAX_WAIT) + 1 : int'($urandom_range(0, MAX_WAIT));
            run_instr(op, fw, mw);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
